// File: rtl/mru_display_pkg.sv
// Shared definitions for the MRU display reader.
// Contents: the reader FSM state type, the blank and dash segment patterns,
// and the hex-to-7-segment glyph table.
// All segment patterns are active low, bit order {g,f,e,d,c,b,a}.
package mru_display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    CAPTURE = 2'd2,
    SHOW    = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment glyph.
// Ports:
//   nibble in  4  hex digit to show
//   seg    out 7  segments {g,f,e,d,c,b,a}, active low
module hex_to_seg7
  import mru_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/mru_display_reader.sv
// Read-side consumer of the MRU value buffer. Cycles through the occupied
// buffer slots, holding a read request long enough for the buffer to answer,
// captures {count, value}, and shows value, slot and count on a multiplexed
// 8-digit active-low 7-segment display.
//
// Optional build macro: MRU_DISPLAY_MANUAL_STEP_EN
//   defined   -> slots advance only on a synchronised rising edge of step
//                seen while in SHOW; SLOT_HOLD is ignored
//   undefined -> slots advance after SLOT_HOLD cycles; step is unused
//
// Ports:
//   clk        in   1  system clock
//   rst        in   1  asynchronous active-high reset
//   enable     in   1  run enable; low freezes all state
//   step       in   1  manual slot-advance button (manual-step build only)
//   req        out  1  read request to the buffer
//   idx        out 16  slot index to the buffer
//   resp       in  20  buffer response {count[3:0], value[15:0]}
//   an         out  8  digit anodes, active low
//   seg        out  7  segments a..g, active low
//   dp         out  1  decimal point, active low, lit on digit 4
//   slot_valid out  1  displayed slot is below the captured count
module mru_display_reader
  import mru_display_pkg::*;
#(
  parameter int unsigned BUF_SIZE    = 8,
  parameter int unsigned REQ_HOLD    = 100000002,
  parameter int unsigned SLOT_HOLD   = 200000000,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        step,
  output logic        req,
  output logic [15:0] idx,
  input  logic [19:0] resp,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        slot_valid
);

  state_t      state, state_next;
  logic [31:0] timer;
  logic [2:0]  slot;
  logic [2:0]  idx_r;
  logic [15:0] value;
  logic [3:0]  count;
  logic        have_data;
  logic [31:0] ref_cnt;
  logic [2:0]  digit;

  logic        timer_clr, load_idx, capture, slot_adv, advance;

  // Slot arithmetic is done at 4 bits so slot+1 cannot wrap before the
  // comparison against the count.
  function automatic logic [2:0] next_slot(input logic [2:0] s, input logic [3:0] c);
    logic [3:0] n;
    n = {1'b0, s} + 4'd1;
    if (n >= c || 32'(n) == BUF_SIZE) return 3'd0;
    return n[2:0];
  endfunction

`ifdef MRU_DISPLAY_MANUAL_STEP_EN
  logic [2:0] step_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         step_sync <= 3'b000;
    else if (enable) step_sync <= {step_sync[1:0], step};
  end

  assign advance = step_sync[1] & ~step_sync[2];
`else
  logic unused_step;
  assign unused_step = step;
  assign advance     = (timer == SLOT_HOLD - 1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         state <= IDLE;
    else if (enable) state <= state_next;
  end

  always_comb begin
    state_next = state;
    timer_clr  = 1'b0;
    load_idx   = 1'b0;
    capture    = 1'b0;
    slot_adv   = 1'b0;
    req        = 1'b0;
    case (state)
      IDLE: begin
        load_idx   = 1'b1;
        timer_clr  = 1'b1;
        state_next = REQUEST;
      end
      REQUEST: begin
        req = 1'b1;
        if (timer == REQ_HOLD - 1) state_next = CAPTURE;
      end
      CAPTURE: begin
        capture    = 1'b1;
        timer_clr  = 1'b1;
        state_next = SHOW;
      end
      SHOW: begin
        if (advance) begin
          slot_adv   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer      <= '0;
      slot       <= '0;
      idx_r      <= '0;
      value      <= '0;
      count      <= '0;
      slot_valid <= 1'b0;
      have_data  <= 1'b0;
    end else if (enable) begin
      timer <= timer_clr ? 32'd0 : timer + 32'd1;
      if (load_idx) idx_r <= slot;
      if (capture) begin
        value      <= resp[15:0];
        count      <= resp[19:16];
        slot_valid <= ({1'b0, slot} < resp[19:16]);
        have_data  <= 1'b1;
      end
      if (slot_adv) slot <= next_slot(slot, count);
    end
  end

  assign idx = {13'd0, idx_r};

  // Display scan: one digit per REFRESH_DIV cycles, independent of the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt <= '0;
      digit   <= '0;
    end else if (enable) begin
      if (ref_cnt == REFRESH_DIV - 1) begin
        ref_cnt <= '0;
        digit   <= digit + 3'd1;
      end else begin
        ref_cnt <= ref_cnt + 32'd1;
      end
    end
  end

  logic [3:0] nib;
  logic [6:0] glyph;
  logic       blank, dash;

  hex_to_seg7 u_hex (
    .nibble (nib),
    .seg    (glyph)
  );

  // Value digits stay blank until a first capture exists, and show dashes
  // when the captured count says the slot is empty.
  always_comb begin
    nib   = 4'd0;
    blank = 1'b0;
    dash  = 1'b0;
    case (digit)
      3'd0: nib = value[3:0];
      3'd1: nib = value[7:4];
      3'd2: nib = value[11:8];
      3'd3: nib = value[15:12];
      3'd4: nib = {1'b0, slot};
      3'd6: nib = count;
      default: blank = 1'b1;
    endcase
    if (digit < 3'd4) begin
      if (!have_data)       blank = 1'b1;
      else if (!slot_valid) dash  = 1'b1;
    end
  end

  assign seg = blank ? SEG_BLANK : (dash ? SEG_DASH : glyph);
  assign an  = ~(8'd1 << digit);
  assign dp  = (digit != 3'd4);

endmodule

// File: tb/tb_mru_display_reader.sv
module tb_mru_display_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        step;
  logic        req;
  logic [15:0] idx;
  logic [19:0] resp;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        slot_valid;

  int tests = 0;
  int fails = 0;

  mru_display_reader #(
    .BUF_SIZE    (8),
    .REQ_HOLD    (4),
    .SLOT_HOLD   (16),
    .REFRESH_DIV (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .step       (step),
    .req        (req),
    .idx        (idx),
    .resp       (resp),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .slot_valid (slot_valid)
  );

  always #5 clk = ~clk;

  // Request monitor: logs slot index and cycle number on every req rise.
  int   cyc = 0;
  logic req_d = 1'b0;
  int   rise_idx[$];
  int   rise_cyc[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (req === 1'b1 && req_d !== 1'b1) begin
      rise_idx.push_back(int'(idx));
      rise_cyc.push_back(cyc);
    end
    req_d = req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_n(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rise_idx.delete();
    rise_cyc.delete();
    step_n(2);
    rst = 1'b0;
  endtask

  task automatic read_digit(input int d, input string tag, output logic [6:0] s, output logic p);
    logic [7:0] want;
    int n;
    want = ~(8'd1 << d);
    n = 0;
    while (an !== want && n < 40) begin
      step_n(1);
      n++;
    end
    chk({tag, "_scan_to"}, 32'(n < 40), 32'd1);
    s = seg;
    p = dp;
  endtask

  task automatic wait_rises(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (rise_idx.size() < n && k < budget) begin
      step_n(1);
      k++;
    end
    chk(tag, 32'(rise_idx.size() >= n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] s;
    logic       p;
    int         hi;
    logic [7:0] an_frz;

    rst = 1'b1; enable = 1'b1; step = 1'b0; resp = 20'h3_1234;
    #3;
    chk("rst_req",   32'(req), 32'd0);
    chk("rst_idx",   32'(idx), 32'd0);
    chk("rst_an",    32'(an),  32'hFE);
    chk("rst_seg",   32'(seg), 32'h7F);
    chk("rst_dp",    32'(dp),  32'd1);
    chk("rst_valid", 32'(slot_valid), 32'd0);

    // First request/capture after reset release, count 3
    step_n(2);
    rst = 1'b0;
    hi = 0;
    for (int i = 1; i <= 4; i++) begin
      step_n(1);
      hi += int'(req);
      chk("req_idx0", 32'(idx), 32'd0);
    end
    chk("req_high_cycles", 32'(hi), 32'd4);
    step_n(1);
    chk("req_low_capture", 32'(req), 32'd0);
    step_n(1);
    chk("valid_after_cap", 32'(slot_valid), 32'd1);

    read_digit(4, "d4", s, p);
    chk("d4_slot0", 32'(s), 32'h40);
    chk("d4_dp",    32'(p), 32'd0);
    read_digit(5, "d5", s, p);
    chk("d5_blank", 32'(s), 32'h7F);
    chk("d5_dp",    32'(p), 32'd1);
    read_digit(6, "d6", s, p);
    chk("d6_cnt3",  32'(s), 32'h30);
    read_digit(0, "d0", s, p);
    chk("d0_4",     32'(s), 32'h19);
    read_digit(1, "d1", s, p);
    chk("d1_3",     32'(s), 32'h30);
    read_digit(2, "d2", s, p);
    chk("d2_2",     32'(s), 32'h24);
    read_digit(3, "d3", s, p);
    chk("d3_1",     32'(s), 32'h79);

    // Slot walk with count 3: 0,1,2,0, 22 cycles per slot
    wait_rises(4, 300, "walk3_rises");
    if (rise_idx.size() >= 4) begin
      chk("walk3_s0", 32'(rise_idx[0]), 32'd0);
      chk("walk3_s1", 32'(rise_idx[1]), 32'd1);
      chk("walk3_s2", 32'(rise_idx[2]), 32'd2);
      chk("walk3_s3", 32'(rise_idx[3]), 32'd0);
      chk("walk3_period01", 32'(rise_cyc[1] - rise_cyc[0]), 32'd22);
      chk("walk3_period12", 32'(rise_cyc[2] - rise_cyc[1]), 32'd22);
    end

    // Enable low freezes FSM and scan (now inside REQUEST)
    enable = 1'b0;
    an_frz = an;
    step_n(10);
    chk("frz_req",   32'(req), 32'd1);
    chk("frz_an",    32'(an),  32'(an_frz));
    chk("frz_rises", 32'(rise_idx.size()), 32'd4);
    enable = 1'b1;

    // Empty buffer: count 0 pins slot 0, dashes on value digits
    resp = 20'h0_0000;
    do_reset();
    step_n(6);
    chk("empty_valid", 32'(slot_valid), 32'd0);
    read_digit(0, "e0", s, p);
    chk("empty_d0_dash", 32'(s), 32'h3F);
    read_digit(3, "e3", s, p);
    chk("empty_d3_dash", 32'(s), 32'h3F);
    read_digit(4, "e4", s, p);
    chk("empty_d4_slot0", 32'(s), 32'h40);
    read_digit(6, "e6", s, p);
    chk("empty_d6_cnt0", 32'(s), 32'h40);
    wait_rises(3, 200, "empty_rises");
    for (int i = 0; i < 3; i++)
      if (i < rise_idx.size()) chk($sformatf("empty_slot_%0d", i), 32'(rise_idx[i]), 32'd0);

    // Full buffer: count 8 walks 0..7 then wraps to 0
    resp = 20'h8_ABCD;
    do_reset();
    wait_rises(9, 400, "full_rises");
    for (int i = 0; i < 9; i++)
      if (i < rise_idx.size()) chk($sformatf("full_slot_%0d", i), 32'(rise_idx[i]), 32'(i % 8));
    read_digit(6, "f6", s, p);
    chk("full_d6_cnt8", 32'(s), 32'h00);
    read_digit(0, "f0", s, p);
    chk("full_d0_d", 32'(s), 32'h21);

    // Asynchronous reset in REQUEST drops req without a clock edge
    resp = 20'h3_1234;
    do_reset();
    step_n(2);
    chk("midreq_req_before", 32'(req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midreq_req_dropped", 32'(req), 32'd0);
    chk("midreq_valid",       32'(slot_valid), 32'd0);
    rise_idx.delete();
    rise_cyc.delete();
    step_n(1);
    rst = 1'b0;
    wait_rises(1, 20, "midreq_restart");
    if (rise_idx.size() >= 1) chk("midreq_slot0", 32'(rise_idx[0]), 32'd0);

`ifdef MRU_DISPLAY_MANUAL_STEP_EN
    // Manual stepping, count 2
    resp = 20'h2_0055;
    do_reset();
    step_n(6);
    step_n(100);
    chk("man_nostep_rises", 32'(rise_idx.size()), 32'd1);
    step = 1'b1;
    step_n(3);
    step = 1'b0;
    wait_rises(2, 20, "man_step_rise");
    if (rise_idx.size() >= 2) chk("man_step_slot1", 32'(rise_idx[1]), 32'd1);
    step = 1'b1;
    step_n(1);
    step = 1'b0;
    step_n(60);
    chk("man_req_pulse_ignored", 32'(rise_idx.size()), 32'd2);
    read_digit(4, "m4", s, p);
    chk("man_d4_slot1", 32'(s), 32'h79);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
